// File: rtl/uart_rx_frame.sv
// 16x-oversampling UART receiver: two-flop line synchroniser, start-bit glitch filter,
// LSB-first data recovery, stop-bit check and a one-deep valid/ready output register.
module uart_rx_frame #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int TICK_DIV  = CLK_FREQ / (BAUD * 16)
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       rx_uart,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);

    localparam int             TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [3:0]     BIT_LAST  = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_sync_p0;
    logic                   r_sync_p1;
    logic                   r_rxs_p2;
    logic [TW-1:0]          r_tick_cnt;
    logic [3:0]             r_smp_cnt;
    logic [3:0]             r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   r_busy;

    logic                   w_rxs;
    logic                   w_fall;
    logic                   w_tick;
    logic                   w_deliver;
    logic [DATA_BITS-1:0]   w_shift_nx;
    logic [7:0]             w_byte;

    assign w_rxs     = r_sync_p1;
    assign w_fall    = r_rxs_p2 & ~w_rxs;
    assign w_tick    = (r_state != IDLE) && (r_tick_cnt == TICK_LAST);
    assign w_deliver = (r_state == STOP) && w_tick && (r_smp_cnt == 4'd15) && w_rxs;
    assign w_byte    = 8'(r_shift);

    // New bits enter at the MSB so the first (LSB) bit ends up in bit 0.
    always_comb begin
        w_shift_nx = r_shift;
        for (int i = 0; i < DATA_BITS - 1; i++) begin
            w_shift_nx[i] = r_shift[i+1];
        end
        w_shift_nx[DATA_BITS-1] = w_rxs;
    end

    // ---- stage p0/p1: line synchroniser, p2: previous value for edge detect
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_p0 <= 1'b1;
            r_sync_p1 <= 1'b1;
            r_rxs_p2  <= 1'b1;
        end else begin
            r_sync_p0 <= rx_uart;
            r_sync_p1 <= r_sync_p0;
            r_rxs_p2  <= r_sync_p1;
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tick_cnt  <= '0;
            r_smp_cnt   <= 4'd0;
            r_bit_cnt   <= 4'd0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (r_state == IDLE || w_tick)
                r_tick_cnt <= '0;
            else
                r_tick_cnt <= r_tick_cnt + 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state   <= START;
                        r_smp_cnt <= 4'd0;
                        r_busy    <= 1'b1;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_smp_cnt == 4'd7) begin
                            if (!w_rxs) begin
                                r_state   <= DATA;
                                r_smp_cnt <= 4'd0;
                                r_bit_cnt <= 4'd0;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_smp_cnt <= r_smp_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_smp_cnt <= r_smp_cnt + 4'd1;
                        if (r_smp_cnt == 4'd15) begin
                            r_shift   <= w_shift_nx;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == BIT_LAST)
                                r_state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_smp_cnt <= r_smp_cnt + 4'd1;
                        if (r_smp_cnt == 4'd15) begin
                            if (w_rxs) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state     <= WAIT_HIGH;
                                r_frame_err <= 1'b1;
                            end
                        end
                    end
                end
                WAIT_HIGH: begin
                    // A break or stuck-low line must not be read as a stream of frames.
                    if (w_rxs) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ---- output register: one-deep, accept and reload may coincide
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_deliver) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data  <= w_byte;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun;
    assign busy        = r_busy;

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Asynchronous-serial receiver: the stage directly downstream of the UART transmitter; consumes the serial line it drives.
- Synchronises the line, oversamples 16x, validates the start bit and recovers LSB-first data bits.
- Checks the stop bit and presents each byte on a one-deep valid/ready output register.
- Reports framing and overrun errors as one-cycle pulses.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- DATA_BITS, 8, data bits per frame (1..8); data is right-aligned in rx_data, upper bits zero.
- TICK_DIV, CLK_FREQ/(BAUD*16) = 325 (integer division), clk_50 cycles per oversample tick.

Ports:
- clk_50  in  1  system clock, all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_uart  in  1  serial line, idle high, asynchronous to clk_50.
- rx_data  out  8  received byte, valid while rx_valid=1.
- rx_valid  out  1  byte available; held until accepted.
- rx_ready  in  1  consumer accepts rx_data on a clk_50 edge when rx_valid=1 and rx_ready=1.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun_err  out  1  one-cycle pulse: completed byte dropped because the output register was full.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset is async active-low; all flops clear on assertion, regardless of clock.
- Reset values:
  - Synchroniser flops = 1.
  - State = IDLE; tick counter = 0; sample counter = 0; bit counter = 0.
  - rx_data = 0, rx_valid = 0, frame_err = 0, overrun_err = 0, busy = 0.
- Reset mid-frame abandons the frame. After release, the receiver waits in IDLE for a fresh falling edge; no partial byte is ever output.
- Synchroniser: 2 flops on rx_uart. All FSM decisions use the synchronised value rxs.
- Tick generator:
  - Counts 0..TICK_DIV-1 and emits a one-cycle tick at wrap.
  - Held at 0 in IDLE; restarts from 0 on start-edge detection, aligning sampling to the edge.
- Sample counter: 4 bits, counts ticks within a bit period.
- FSM states and transitions:
  - IDLE: on rxs 1->0 (previous synchronised value 1, current 0) -> START; sample counter = 0.
  - START: on the 8th tick (mid-bit), sample rxs.
    - rxs=0 -> DATA; sample counter = 0; bit counter = 0.
    - rxs=1 -> IDLE (glitch rejected, no error flagged).
  - DATA: on every 16th tick, shift rxs into the shift register at the MSB side of a DATA_BITS-wide register, LSB first.
    - After the DATA_BITS-th sample -> STOP.
  - STOP: on the 16th tick, sample rxs.
    - rxs=1: deliver byte, then -> IDLE.
    - rxs=0: pulse frame_err for 1 cycle, discard byte, -> WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then -> IDLE. A held-low or break line never produces repeated frames.
- Delivery latency: rx_valid rises on the clk_50 edge after the stop-bit sample cycle.
  - Line edge to first recognition is 2-3 clocks, due to the synchroniser.
- Output register rules:
  - rx_valid=0 at delivery: load rx_data, set rx_valid=1.
  - rx_valid=1 and rx_ready=0 at delivery: keep the old byte, pulse overrun_err, drop the new byte.
  - rx_valid=1 and rx_ready=1 in the same cycle as delivery: the old byte is consumed and the new byte loaded. rx_valid stays 1; no overrun.
  - rx_valid=1, rx_ready=1, no delivery: clear rx_valid next edge. rx_data holds its value.
  - rx_ready while rx_valid=0 is ignored.
- frame_err and overrun_err are never asserted together; a framing-error frame never attempts delivery.

Test Plan:
- Single frame: idle 1, frame 0xA5 at 9600 (start, bits 1,0,1,0,0,1,0,1, stop) -> rx_valid=1 with rx_data=0xA5 one clk after the mid-stop sample; no error pulses; busy low afterwards.
- Back-to-back sequence: 0x80, 0xC0, 0xE0, 0xF0 with one stop bit each, rx_ready tied 1 -> four single-cycle rx_valid pulses in order; idle line between frames is not required.
- Glitch: rx_uart low for 3 tick periods (~975 clks), then high -> returns to IDLE; no rx_valid, no frame_err; a following 0x3C frame is received correctly.
- Framing error: frame 0x55 with stop bit 0, line held low 2 more bit times -> exactly one frame_err pulse, no rx_valid, busy high until the line returns high.
- Overrun and simultaneity:
  - rx_ready=0; send 0x11, then 0x22 -> rx_data stays 0x11 and overrun_err pulses once.
  - Repeat with rx_ready=1 asserted exactly in the delivery cycle of 0x22 -> rx_data=0x22, rx_valid remains 1, no overrun.
- Reset mid-frame: assert rst_n=0 asynchronously (between clk edges) during data bit 4 of 0x96 -> all outputs 0 immediately; no byte after release; next full frame 0x69 received correctly.
